// File: rtl/otter_ifetch_pkg.sv
// Shared constants for the otter instruction-fetch slice: default queue depth
// and the bit layout of an instruction-queue entry {err, pc, instr}.
package otter_ifetch_pkg;

    localparam int OTTER_IFETCH_DEPTH_DEFAULT = 2;

    localparam int IQ_INSTR_OFF = 0;
    localparam int IQ_INSTR_W   = 32;
    localparam int IQ_PC_OFF    = IQ_INSTR_OFF + IQ_INSTR_W;

    function automatic int iq_err_off(input int pc_w);
        return IQ_PC_OFF + pc_w;
    endfunction

    function automatic int iq_width(input int pc_w);
        return IQ_PC_OFF + pc_w + 1;
    endfunction

endpackage

// File: rtl/otter_sync_fifo.sv
// Small synchronous show-ahead FIFO with a synchronous clear; head reads as
// zero while empty so downstream data outputs stay quiet.
module otter_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
        head  = empty ? '0 : mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked by empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/otter_ifetch.sv
// Instruction-fetch responder: issues PC-stage addresses on a req/gnt/rvalid
// bus, queues returned words with their PCs, and drops fetches killed by a flush.
module otter_ifetch
    import otter_ifetch_pkg::*;
#(
    parameter int DEPTH = OTTER_IFETCH_DEPTH_DEFAULT,
    parameter int PC_W  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [PC_W-1:0] i_pc_addr,
    input  logic            i_pc_valid,
    output logic            o_stall,
    input  logic            i_flush,
    output logic            o_mem_req,
    output logic [PC_W-1:0] o_mem_addr,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [31:0]     i_mem_rdata,
    input  logic            i_mem_err,
    output logic            o_instr_valid,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_instr_pc,
    output logic            o_instr_err,
    input  logic            i_instr_ready
);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int IQ_W    = iq_width(PC_W);
    localparam int ERR_OFF = iq_err_off(PC_W);

    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   iq_count, pq_count;
    logic            iq_empty, iq_full, pq_empty, pq_full;
    logic [IQ_W-1:0] iq_head, iq_din;
    logic [PC_W-1:0] pq_head;
    logic [CW+1:0]   inflight;
    logic            credit, grant, resp_ok, resp_drop, iq_push, iq_pop;

    always_comb begin
        inflight   = (CW+2)'(outstanding_q) + (CW+2)'(discard_q) + (CW+2)'(iq_count);
        credit     = inflight < (CW+2)'(DEPTH);
        o_mem_addr = {i_pc_addr[PC_W-1:2], 2'b00};
        o_mem_req  = i_rst_n & i_pc_valid & credit & ~i_flush;
        grant      = o_mem_req & i_mem_gnt;
        o_stall    = i_pc_valid & ~grant;
        // A response belongs to a killed fetch whenever any discard is pending.
        resp_drop  = i_mem_rvalid & (discard_q != '0);
        resp_ok    = i_mem_rvalid & (discard_q == '0) & (outstanding_q != '0);
        iq_push    = resp_ok & ~i_flush;
        iq_pop     = ~iq_empty & i_instr_ready & ~i_flush;
        iq_din     = {i_mem_err, pq_head, i_mem_rdata};
    end

    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (i_flush) begin
            outstanding_d = '0;
            // Everything still owed by memory becomes a discard, less one if it lands now.
            if ((outstanding_q != '0) || (discard_q != '0)) begin
                discard_d = discard_q + outstanding_q - CW'(i_mem_rvalid);
            end
        end else begin
            outstanding_d = outstanding_q + CW'(grant) - CW'(resp_ok);
            discard_d     = discard_q - CW'(resp_drop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    otter_sync_fifo #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) u_pending_q (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (grant),
        .pop   (resp_ok),
        .clear (i_flush),
        .din   (o_mem_addr),
        .head  (pq_head),
        .full  (pq_full),
        .empty (pq_empty),
        .count (pq_count)
    );

    otter_sync_fifo #(
        .WIDTH (IQ_W),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (iq_push),
        .pop   (iq_pop),
        .clear (i_flush),
        .din   (iq_din),
        .head  (iq_head),
        .full  (iq_full),
        .empty (iq_empty),
        .count (iq_count)
    );

    always_comb begin
        o_instr_valid = ~iq_empty;
        o_instr       = iq_head[IQ_INSTR_OFF +: IQ_INSTR_W];
        o_instr_pc    = iq_head[IQ_PC_OFF +: PC_W];
        o_instr_err   = iq_head[ERR_OFF];
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(i_mem_rvalid && outstanding_q == '0 && discard_q == '0))
                else $error("otter_ifetch: rvalid with no fetch outstanding");
            assert (pq_count == outstanding_q && (pq_empty == (outstanding_q == '0)))
                else $error("otter_ifetch: pending queue out of step with outstanding");
            assert (!(grant && pq_full))
                else $error("otter_ifetch: grant into full pending queue");
            assert (!(iq_push && iq_full))
                else $error("otter_ifetch: response into full instruction queue");
        end
    end
`endif

endmodule

// File: tb/tb_otter_ifetch.sv
// Directed bench for otter_ifetch: a DEPTH=4 instance for streaming, flush and
// error cases, and a DEPTH=2 instance for credit exhaustion.
module tb_otter_ifetch;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] pc_addr = '0, rdata = '0;
    logic        pc_valid = 0, flush = 0, gnt = 0, rvalid = 0, err = 0, ready = 0;
    logic        stall, mem_req, ivalid, ierr;
    logic [31:0] mem_addr, instr, ipc;

    logic [31:0] b_pc_addr = '0, b_rdata = '0;
    logic        b_pc_valid = 0, b_flush = 0, b_gnt = 0, b_rvalid = 0, b_err = 0, b_ready = 0;
    logic        b_stall, b_mem_req, b_ivalid, b_ierr;
    logic [31:0] b_mem_addr, b_instr, b_ipc;

    otter_ifetch #(.DEPTH(4), .PC_W(32)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc_addr(pc_addr), .i_pc_valid(pc_valid),
        .o_stall(stall), .i_flush(flush), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_gnt(gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata), .i_mem_err(err),
        .o_instr_valid(ivalid), .o_instr(instr), .o_instr_pc(ipc), .o_instr_err(ierr),
        .i_instr_ready(ready)
    );

    otter_ifetch #(.DEPTH(2), .PC_W(32)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc_addr(b_pc_addr), .i_pc_valid(b_pc_valid),
        .o_stall(b_stall), .i_flush(b_flush), .o_mem_req(b_mem_req), .o_mem_addr(b_mem_addr),
        .i_mem_gnt(b_gnt), .i_mem_rvalid(b_rvalid), .i_mem_rdata(b_rdata), .i_mem_err(b_err),
        .o_instr_valid(b_ivalid), .o_instr(b_instr), .o_instr_pc(b_ipc), .o_instr_err(b_ierr),
        .i_instr_ready(b_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        pc_valid = 1'b1; pc_addr = 32'h10; b_pc_valid = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b want=0", ivalid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instr); end
        total++; if (ipc !== 32'h0) begin bad++; $display("FAIL rst_ipc got=%h want=0", ipc); end
        total++; if (ierr !== 1'b0) begin bad++; $display("FAIL rst_ierr got=%b want=0", ierr); end
        total++; if (b_mem_req !== 1'b0) begin bad++; $display("FAIL rst_b_req got=%b want=0", b_mem_req); end
        total++; if (b_ivalid !== 1'b0) begin bad++; $display("FAIL rst_b_ivalid got=%b want=0", b_ivalid); end
        pc_valid = 1'b0; b_pc_valid = 1'b0; pc_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Zero-wait memory: gnt always high, response the cycle after the grant.
    task automatic test_zero_wait();
        logic [31:0] exp_pc;
        gnt = 1'b1; ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            pc_valid = (c < 3);
            pc_addr  = 32'(c * 4);
            rvalid   = (c >= 1 && c <= 3);
            rdata    = 32'hA000_0000 + 32'((c - 1) * 4);
            #1;
            total++; if (mem_req !== (c < 3)) begin bad++; $display("FAIL zw_req c%0d got=%b want=%b", c, mem_req, (c < 3)); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL zw_stall c%0d got=%b want=0", c, stall); end
            total++; if (ivalid !== (c >= 2 && c <= 4)) begin bad++; $display("FAIL zw_ivalid c%0d got=%b want=%b", c, ivalid, (c >= 2 && c <= 4)); end
            if (c >= 2 && c <= 4) begin
                exp_pc = 32'((c - 2) * 4);
                total++; if (ipc !== exp_pc) begin bad++; $display("FAIL zw_ipc c%0d got=%h want=%h", c, ipc, exp_pc); end
                total++; if (instr !== 32'hA000_0000 + exp_pc) begin bad++; $display("FAIL zw_instr c%0d got=%h want=%h", c, instr, 32'hA000_0000 + exp_pc); end
            end
            if (c == 0) begin
                total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL zw_addr got=%h want=0", mem_addr); end
            end
        end
        rvalid = 1'b0; pc_valid = 1'b0;
    endtask

    task automatic test_gnt_wait();
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            pc_valid = 1'b1; pc_addr = 32'h103; gnt = 1'b0;
            #1;
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL gw_req c%0d got=%b want=1", c, mem_req); end
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL gw_stall c%0d got=%b want=1", c, stall); end
            total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL gw_addr c%0d got=%h want=100", c, mem_addr); end
        end
        tick(); gnt = 1'b1; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL gw_stall_gnt got=%b want=0", stall); end
        tick(); pc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hB000_0100; ready = 1'b0; #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL gw_req_idle got=%b want=0", mem_req); end
        tick(); rvalid = 1'b0; #1;
        total++; if (ivalid !== 1'b1 || ipc !== 32'h100) begin bad++; $display("FAIL gw_head got=%b/%h want=1/100", ivalid, ipc); end
        total++; if (instr !== 32'hB000_0100) begin bad++; $display("FAIL gw_instr got=%h want=b0000100", instr); end
        tick(); ready = 1'b1; #1;
        total++; if (ivalid !== 1'b1) begin bad++; $display("FAIL gw_hold got=%b want=1", ivalid); end
        tick(); #1;
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL gw_single got=%b want=0", ivalid); end
    endtask

    task automatic test_credit();
        b_ready = 1'b0; b_gnt = 1'b1;
        tick(); b_pc_valid = 1'b1; b_pc_addr = 32'h20; #1;
        total++; if (b_mem_req !== 1'b1) begin bad++; $display("FAIL cr_req0 got=%b want=1", b_mem_req); end
        tick(); b_pc_addr = 32'h24; b_rvalid = 1'b1; b_rdata = 32'hC000_0020; #1;
        total++; if (b_mem_req !== 1'b1) begin bad++; $display("FAIL cr_req1 got=%b want=1", b_mem_req); end
        tick(); b_pc_addr = 32'h28; b_rdata = 32'hC000_0024; #1;
        total++; if (b_mem_req !== 1'b0 || b_stall !== 1'b1) begin bad++; $display("FAIL cr_full got=%b/%b want=0/1", b_mem_req, b_stall); end
        tick(); b_rvalid = 1'b0; b_ready = 1'b1; #1;
        total++; if (b_mem_req !== 1'b0 || b_stall !== 1'b1) begin bad++; $display("FAIL cr_popcyc got=%b/%b want=0/1", b_mem_req, b_stall); end
        total++; if (b_ivalid !== 1'b1 || b_ipc !== 32'h20 || b_instr !== 32'hC000_0020) begin bad++; $display("FAIL cr_head0 got=%b/%h/%h want=1/20/c0000020", b_ivalid, b_ipc, b_instr); end
        tick(); b_ready = 1'b0; #1;
        total++; if (b_mem_req !== 1'b1 || b_stall !== 1'b0) begin bad++; $display("FAIL cr_resume got=%b/%b want=1/0", b_mem_req, b_stall); end
        total++; if (b_mem_addr !== 32'h28) begin bad++; $display("FAIL cr_addr got=%h want=28", b_mem_addr); end
        total++; if (b_ipc !== 32'h24) begin bad++; $display("FAIL cr_head1 got=%h want=24", b_ipc); end
        tick(); b_pc_valid = 1'b0; b_rvalid = 1'b1; b_rdata = 32'hC000_0028; #1;
        tick(); b_rvalid = 1'b0; b_ready = 1'b1; #1;
        total++; if (b_ipc !== 32'h24 || b_instr !== 32'hC000_0024) begin bad++; $display("FAIL cr_drain0 got=%h/%h want=24/c0000024", b_ipc, b_instr); end
        tick(); #1;
        total++; if (b_ipc !== 32'h28 || b_instr !== 32'hC000_0028) begin bad++; $display("FAIL cr_drain1 got=%h/%h want=28/c0000028", b_ipc, b_instr); end
        tick(); b_ready = 1'b0; b_gnt = 1'b0; #1;
        total++; if (b_ivalid !== 1'b0) begin bad++; $display("FAIL cr_empty got=%b want=0", b_ivalid); end
    endtask

    task automatic test_flush_head();
        ready = 1'b0; gnt = 1'b1;
        tick(); pc_valid = 1'b1; pc_addr = 32'h50; #1;
        tick(); pc_valid = 1'b0; rvalid = 1'b1; rdata = 32'hF000_0050; #1;
        tick(); rvalid = 1'b0; flush = 1'b1; ready = 1'b1; pc_valid = 1'b1; pc_addr = 32'h60; #1;
        total++; if (ivalid !== 1'b1 || ipc !== 32'h50) begin bad++; $display("FAIL fh_prehead got=%b/%h want=1/50", ivalid, ipc); end
        total++; if (mem_req !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL fh_req got=%b/%b want=0/1", mem_req, stall); end
        tick(); flush = 1'b0; pc_valid = 1'b0; ready = 1'b0; #1;
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fh_after got=%b want=0", ivalid); end
    endtask

    task automatic test_flush_drop();
        ready = 1'b1; gnt = 1'b1;
        tick(); pc_valid = 1'b1; pc_addr = 32'h10; #1;
        tick(); pc_addr = 32'h14; #1;
        tick(); flush = 1'b1; pc_addr = 32'h200; #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fd_flushreq got=%b want=0", mem_req); end
        tick(); flush = 1'b0; rvalid = 1'b1; rdata = 32'hD000_0010; #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL fd_newreq got=%b/%h want=1/200", mem_req, mem_addr); end
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fd_v0 got=%b want=0", ivalid); end
        tick(); pc_valid = 1'b0; rdata = 32'hD000_0014; #1;
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fd_v1 got=%b want=0", ivalid); end
        tick(); rdata = 32'hD000_0200; #1;
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fd_v2 got=%b want=0", ivalid); end
        tick(); rvalid = 1'b0; #1;
        total++; if (ivalid !== 1'b1 || ipc !== 32'h200 || instr !== 32'hD000_0200) begin bad++; $display("FAIL fd_new got=%b/%h/%h want=1/200/d0000200", ivalid, ipc, instr); end
        tick(); #1;
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fd_end got=%b want=0", ivalid); end
    endtask

    task automatic test_flush_rvalid();
        ready = 1'b1; gnt = 1'b1;
        tick(); pc_valid = 1'b1; pc_addr = 32'h10; #1;
        tick(); pc_addr = 32'h14; #1;
        tick(); flush = 1'b1; pc_addr = 32'h300; rvalid = 1'b1; rdata = 32'hE000_0010; #1;
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fr_v0 got=%b want=0", ivalid); end
        tick(); flush = 1'b0; rdata = 32'hE000_0014; #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("FAIL fr_req got=%b/%h want=1/300", mem_req, mem_addr); end
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fr_v1 got=%b want=0", ivalid); end
        tick(); pc_valid = 1'b0; rdata = 32'hE000_0300; #1;
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fr_v2 got=%b want=0", ivalid); end
        tick(); rvalid = 1'b0; #1;
        total++; if (ivalid !== 1'b1 || ipc !== 32'h300 || instr !== 32'hE000_0300) begin bad++; $display("FAIL fr_new got=%b/%h/%h want=1/300/e0000300", ivalid, ipc, instr); end
        tick(); #1;
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL fr_end got=%b want=0", ivalid); end
    endtask

    task automatic test_err_reset();
        ready = 1'b0; gnt = 1'b1;
        tick(); pc_valid = 1'b1; pc_addr = 32'h40; #1;
        tick(); pc_addr = 32'h44; rvalid = 1'b1; err = 1'b1; rdata = 32'hDEAD_BEEF; #1;
        tick(); pc_addr = 32'h48; rvalid = 1'b0; err = 1'b0; gnt = 1'b0; #1;
        total++; if (ivalid !== 1'b1 || ierr !== 1'b1 || ipc !== 32'h40) begin bad++; $display("FAIL er_head got=%b/%b/%h want=1/1/40", ivalid, ierr, ipc); end
        total++; if (instr !== 32'hDEAD_BEEF) begin bad++; $display("FAIL er_instr got=%h want=deadbeef", instr); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL er_req_pre got=%b want=1", mem_req); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (ivalid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL er_rst got=%b/%b want=0/0", ivalid, mem_req); end
        total++; if (ierr !== 1'b0 || ipc !== 32'h0) begin bad++; $display("FAIL er_rst_data got=%b/%h want=0/0", ierr, ipc); end
        pc_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); #1;
        total++; if (ivalid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL er_post got=%b/%b want=0/0", ivalid, mem_req); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_gnt_wait();
        test_credit();
        test_flush_head();
        test_flush_drop();
        test_flush_rvalid();
        test_err_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
